// File: rtl/spi_cmd_regfile.sv
// Command decoder and register file fed by an SPI slave byte receiver.
// Define SPI_CMD_FRAME_CNT_EN to map a read-only frame counter at address 0xF.
module spi_cmd_regfile #(
    parameter int unsigned NUM_REGS = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic [4:0] leds,
    output logic       busy,
    output logic       wr_err
);

    typedef enum logic [1:0] {StIdle, StCmd, StRead, StWrite} state_e;

    state_e     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic       wr_err_q, wr_err_d;
    logic       reg_we;
    // Full 16-entry array so the 4-bit address indexes it directly; unimplemented
    // entries are never written and stay at their reset value.
    logic [7:0] regs_q [16];

`ifdef SPI_CMD_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic       cnt_inc;
`endif

    function automatic logic is_writable(input logic [3:0] a);
        return (a != 4'd0) && ({28'd0, a} < NUM_REGS);
    endfunction

    function automatic logic [7:0] read_reg(input logic [3:0] a);
        if (a == 4'd0) return ID_VALUE;
`ifdef SPI_CMD_FRAME_CNT_EN
        if (a == 4'hF) return frame_cnt_q;
`endif
        if ({28'd0, a} < NUM_REGS) return regs_q[a];
        return 8'h00;
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tx_d     = tx_q;
        wr_err_d = 1'b0;
        reg_we   = 1'b0;
`ifdef SPI_CMD_FRAME_CNT_EN
        cnt_inc  = 1'b0;
`endif
        if (frame_start) begin
            // Also covers a lost frame_end: restart without committing anything.
            state_d = StCmd;
            tx_d    = ID_VALUE;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    StCmd: begin
                        addr_d = rx_data[3:0];
                        if (rx_data[7]) begin
                            state_d = StWrite;
                            tx_d    = 8'h00;
                        end else begin
                            state_d = StRead;
                            tx_d    = read_reg(rx_data[3:0]);
                        end
                    end
                    StRead: begin
                        addr_d = addr_q + 4'd1;
                        tx_d   = read_reg(addr_q + 4'd1);
                    end
                    StWrite: begin
                        if (is_writable(addr_q)) reg_we = 1'b1;
                        else                     wr_err_d = 1'b1;
                        addr_d = addr_q + 4'd1;
                        tx_d   = 8'h00;
                    end
                    default: ;
                endcase
            end
            if (frame_end) begin
`ifdef SPI_CMD_FRAME_CNT_EN
                cnt_inc = (state_q != StIdle);
`endif
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 4'd0;
            tx_q     <= 8'h00;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else if (reg_we) begin
            if (addr_q == 4'd1) regs_q[1] <= {3'b000, rx_data[4:0]};
            else                regs_q[addr_q] <= rx_data;
        end
    end

`ifdef SPI_CMD_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)          frame_cnt_q <= 8'h00;
        else if (cnt_inc) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
`endif

    assign tx_data = tx_q;
    assign leds    = regs_q[1][4:0];
    assign busy    = (state_q != StIdle);
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomized scoreboard bench for spi_cmd_regfile against a frame-level reference model.
// Honours SPI_CMD_FRAME_CNT_EN the same way as the design.
module tb_spi_cmd_regfile;

    localparam int unsigned NUM_REGS = 8;
    localparam logic [7:0]  ID_VALUE = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic [4:0] leds;
    logic       busy;
    logic       wr_err;

    always #5 clk = ~clk;

    spi_cmd_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .leds        (leds),
        .busy        (busy),
        .wr_err      (wr_err)
    );

    typedef struct {
        int         due;
        logic [7:0] tx;
        logic [4:0] leds;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frame-level view of the protocol.
    bit         m_in_frame, m_got_cmd, m_wmode;
    int         m_ptr;
    logic [7:0] m_mem [16];
    logic [7:0] m_cnt;
    logic [7:0] m_tx;

    function automatic logic [7:0] peek(input int a);
        if (a == 0) return ID_VALUE;
`ifdef SPI_CMD_FRAME_CNT_EN
        if (a == 15) return m_cnt;
`endif
        if (a == 1) return m_mem[1] & 8'h1F;
        if (a < int'(NUM_REGS)) return m_mem[a];
        return 8'h00;
    endfunction

    task automatic step(input bit r, input bit fs, input bit fe, input bit rv,
                        input logic [7:0] d);
        exp_t e;
        bit   err;
        err = 1'b0;
        @(negedge clk);
        rst = r; frame_start = fs; frame_end = fe; rx_valid = rv; rx_data = d;
        if (r) begin
            m_in_frame = 0; m_got_cmd = 0; m_wmode = 0; m_ptr = 0;
            m_tx = 8'h00; m_cnt = 8'h00;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else if (fs) begin
            m_in_frame = 1; m_got_cmd = 0; m_tx = ID_VALUE;
        end else begin
            if (rv && m_in_frame) begin
                if (!m_got_cmd) begin
                    m_got_cmd = 1;
                    m_ptr     = int'(d & 8'h0F);
                    m_wmode   = d[7];
                    m_tx      = m_wmode ? 8'h00 : peek(m_ptr);
                end else if (m_wmode) begin
                    if (m_ptr >= 1 && m_ptr < int'(NUM_REGS)) m_mem[m_ptr] = d;
                    else err = 1'b1;
                    m_ptr = (m_ptr + 1) % 16;
                    m_tx  = 8'h00;
                end else begin
                    m_ptr = (m_ptr + 1) % 16;
                    m_tx  = peek(m_ptr);
                end
            end
            if (fe) begin
                if (m_in_frame) m_cnt = m_cnt + 8'd1;
                m_in_frame = 0;
            end
        end
        e.due  = cyc + 1;
        e.tx   = m_tx;
        e.leds = m_mem[1][4:0];
        e.busy = m_in_frame;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 8'($urandom));
    endtask

    task automatic do_frame(input logic [7:0] cmd, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit merge_end);
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        step(0, 1, 0, 0, 8'h00);
        idle($urandom_range(0, 2));
        step(0, 0, 0, 1, cmd);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            if (merge_end && i == n - 1) step(0, 0, 1, 1, b[i]);
            else                         step(0, 0, 0, 1, b[i]);
        end
        if (!merge_end || n == 0) begin
            idle($urandom_range(0, 2));
            step(0, 0, 1, 0, 8'h00);
        end
        idle(1);
    endtask

    // Monitor: every cycle the DUT presents a state; check it against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (tx_data !== e.tx || leds !== e.leds || busy !== e.busy ||
                    wr_err !== e.err) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got tx=%h leds=%b busy=%b wr_err=%b, want tx=%h leds=%b busy=%b wr_err=%b",
                             cyc, tx_data, leds, busy, wr_err, e.tx, e.leds, e.busy, e.err);
                end
            end
        end
    end

    initial begin
        logic [7:0] cmd;
        int         n;
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        idle(2);
        // Bare frame: ID appears, busy follows the frame markers.
        step(0, 1, 0, 0, 8'h00);
        idle(2);
        step(0, 0, 1, 0, 8'h00);
        idle(2);
        do_frame(8'h81, 1, 8'h1F, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h81, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        do_frame(8'h82, 3, 8'h11, 8'h22, 8'h33, 8'h00, 0);
        do_frame(8'h02, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);
        do_frame(8'h80, 1, 8'h55, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h87, 2, 8'h01, 8'h02, 8'h00, 8'h00, 1);
        do_frame(8'h07, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h0F, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h9F, 1, 8'h77, 8'h00, 8'h00, 8'h00, 0);
        // Reset mid-write: the following data byte must not land.
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h81);
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h1F);
        idle(2);
        step(0, 0, 1, 0, 8'h00);
        // Three frames after reset, then read the counter slot.
        do_frame(8'h03, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h83, 1, 8'h3C, 8'h00, 8'h00, 8'h00, 0);
        do_frame(8'h01, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        do_frame(8'h0F, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // Lost frame_end: restart with a byte arriving on the same cycle.
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h83);
        step(0, 0, 0, 1, 8'h44);
        step(0, 1, 0, 1, 8'h99);
        step(0, 0, 0, 1, 8'h03);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        idle(1);
        // Random well-formed frames.
        for (int k = 0; k < 60; k++) begin
            cmd = 8'($urandom);
            n   = $urandom_range(0, 4);
            do_frame(cmd, n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom));
        end
        // Unstructured random traffic, including lost markers and stray resets.
        for (int k = 0; k < 400; k++) begin
            int p;
            p = $urandom_range(0, 99);
            step(p == 0, p >= 1 && p < 6, p >= 6 && p < 14,
                 (p >= 10 && p < 55), 8'($urandom));
        end
        step(0, 0, 1, 0, 8'h00);
        idle(2);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
